// File: rtl/char_scroll_if.sv
// Bus bundle for char_scroll_display: control inputs from switches/keys and
// the display outputs toward the HEXn pins.
interface char_scroll_if #(
  parameter int NUM_DISP = 5,
  parameter int MSG_LEN  = 8,
  parameter int DIV_W    = 26
);
  localparam int OFF_W = $clog2(MSG_LEN);

  // No valid/ready pairing here: load and step are single-cycle strobes sampled
  // on every rising edge; run/dir/period are levels; adv_out is a one-cycle
  // pulse coincident with each offset change.
  logic                    load;
  logic [3*MSG_LEN-1:0]    msg_in;
  logic                    run;
  logic                    dir;
  logic                    step;
  logic [DIV_W-1:0]        period;
  logic [7*NUM_DISP-1:0]   hex_out;
  logic [OFF_W-1:0]        offset_out;
  logic                    adv_out;

  modport master (
    output load, msg_in, run, dir, step, period,
    input  hex_out, offset_out, adv_out
  );

  modport slave (
    input  load, msg_in, run, dir, step, period,
    output hex_out, offset_out, adv_out
  );
endinterface

// File: rtl/char_scroll_display.sv
// Scrolling message display: MSG_LEN 3-bit character codes shown through a
// NUM_DISP-wide window on active-low 7-segment digits, auto or single-step.
module char_scroll_display #(
  parameter int NUM_DISP = 5,
  parameter int MSG_LEN  = 8,
  parameter int DIV_W    = 26
) (
  input  logic         clk,
  input  logic         rst,
  char_scroll_if.slave bus
);
  localparam int OFF_W = $clog2(MSG_LEN);

  logic [MSG_LEN-1:0][2:0]  msg_q, msg_d;
  logic [OFF_W-1:0]         offset_q, offset_d;
  logic [DIV_W-1:0]         cnt_q, cnt_d;
  logic                     adv_q, adv_d;
  logic [7*NUM_DISP-1:0]    hex_q, hex_d;
  logic                     adv;

  function automatic logic [6:0] char_seg(input logic [2:0] code);
    case (code)
      3'd0:    char_seg = 7'b0001001; // H
      3'd1:    char_seg = 7'b0000110; // E
      3'd2:    char_seg = 7'b1000111; // L
      3'd3:    char_seg = 7'b1000000; // O
      default: char_seg = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    adv      = bus.run ? (cnt_q == bus.period) : bus.step;
    msg_d    = msg_q;
    offset_d = offset_q;
    cnt_d    = '0;
    adv_d    = 1'b0;

    if (bus.load) begin
      msg_d    = bus.msg_in;
      offset_d = '0;
    end else begin
      adv_d = adv;
      if (bus.run && (cnt_q != bus.period)) begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      if (adv) begin
        if (!bus.dir) begin
          offset_d = (offset_q == OFF_W'(MSG_LEN - 1)) ? '0 : offset_q + OFF_W'(1);
        end else begin
          offset_d = (offset_q == '0) ? OFF_W'(MSG_LEN - 1) : offset_q - OFF_W'(1);
        end
      end
    end
  end

  // Display decode uses the registered state, so hex_out trails msg/offset by one clock.
  always_comb begin
    hex_d = '1;
    for (int d = 0; d < NUM_DISP; d++) begin
      int idx_i;
      idx_i = (int'(offset_q) + NUM_DISP - 1 - d) % MSG_LEN;
      hex_d[7*d +: 7] = char_seg(msg_q[idx_i[OFF_W-1:0]]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q    <= '1;
      offset_q <= '0;
      cnt_q    <= '0;
      adv_q    <= 1'b0;
      hex_q    <= '1;
    end else begin
      msg_q    <= msg_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      adv_q    <= adv_d;
      hex_q    <= hex_d;
    end
  end

  assign bus.hex_out    = hex_q;
  assign bus.offset_out = offset_q;
  assign bus.adv_out    = adv_q;
endmodule

// File: tb/tb_char_scroll_display.sv
// Bench for char_scroll_display: directed test-plan sequences plus random
// traffic, checked cycle by cycle against a message/offset reference model.
module tb_char_scroll_display;
  localparam int ND = 5;
  localparam int ML = 8;
  localparam int DW = 26;
  localparam int OW = $clog2(ML);
  localparam int W  = 7*ND + OW + 1;

  localparam logic [6:0] S_H = 7'b0001001;
  localparam logic [6:0] S_E = 7'b0000110;
  localparam logic [6:0] S_L = 7'b1000111;
  localparam logic [6:0] S_O = 7'b1000000;
  localparam logic [6:0] S_B = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  char_scroll_if #(.NUM_DISP(ND), .MSG_LEN(ML), .DIV_W(DW)) bus ();

  char_scroll_display #(.NUM_DISP(ND), .MSG_LEN(ML), .DIV_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: message as a list of codes, offset as a plain integer.
  int     m_msg[ML];
  int     m_off;
  longint m_cnt;

  function automatic logic [6:0] char_seg(input int c);
    case (c)
      0:       return S_H;
      1:       return S_E;
      2:       return S_L;
      3:       return S_O;
      default: return S_B;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] model_hex();
    logic [7*ND-1:0] r;
    for (int d = 0; d < ND; d++) begin
      r[7*d +: 7] = char_seg(m_msg[(m_off + ND - 1 - d) % ML]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ML; i++) m_msg[i] = 7;
    m_off = 0;
    m_cnt = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs and push the expected post-edge outputs.
  task automatic drive(input logic ld, input logic [3*ML-1:0] mi, input logic r,
                       input logic d, input logic s, input logic [DW-1:0] p);
    logic [7*ND-1:0] hex_e;
    logic            adv, adv_e;
    @(negedge clk);
    bus.load = ld; bus.msg_in = mi; bus.run = r; bus.dir = d; bus.step = s; bus.period = p;
    hex_e = model_hex();
    adv   = r ? (m_cnt == longint'(p)) : s;
    if (ld) begin
      for (int i = 0; i < ML; i++) m_msg[i] = int'(mi[3*i +: 3]);
      m_off = 0;
      m_cnt = 0;
      adv_e = 1'b0;
    end else begin
      if (adv) m_off = d ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
      if (!r || m_cnt == longint'(p)) m_cnt = 0;
      else m_cnt = (m_cnt + 1) % (longint'(1) << DW);
      adv_e = adv;
    end
    exp_q.push_back({hex_e, OW'(m_off), adv_e});
  endtask

  logic [3*ML-1:0] hello;
  logic [DW-1:0]   cur_p = '0;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, hello, 1'b0, 1'b0, 1'b0, cur_p);
  endtask

  // Monitor: compares DUT outputs just after every active edge.
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", 64'({bus.hex_out, bus.offset_out, bus.adv_out}), 64'(e));
    end
  end

  initial begin
    int codes[ML];
    codes = '{0, 1, 2, 2, 3, 7, 7, 7};
    for (int i = 0; i < ML; i++) hello[3*i +: 3] = 3'(codes[i]);

    rst = 1'b0;
    bus.load = 1'b0; bus.msg_in = '0; bus.run = 1'b0; bus.dir = 1'b0;
    bus.step = 1'b0; bus.period = '0;
    model_reset();
    #2 rst = 1'b1;
    #1;
    check("reset_hex", 64'(bus.hex_out), 64'({ND{S_B}}));
    check("reset_off", 64'(bus.offset_out), 64'(0));
    check("reset_adv", 64'(bus.adv_out), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load HELLO and see it within two clocks.
    drive(1'b1, hello, 1'b0, 1'b0, 1'b0, cur_p);
    idle(2);
    check("load_hex", 64'(bus.hex_out), 64'({S_H, S_E, S_L, S_L, S_O}));
    check("load_off", 64'(bus.offset_out), 64'(0));

    // Single steps left.
    drive(1'b0, hello, 1'b0, 1'b0, 1'b1, cur_p);
    idle(2);
    check("step1_off", 64'(bus.offset_out), 64'(1));
    check("step1_hex", 64'(bus.hex_out), 64'({S_E, S_L, S_L, S_O, S_B}));
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, hello, 1'b0, 1'b0, 1'b1, cur_p);
      idle(1);
    end
    idle(2);
    check("wrap_off", 64'(bus.offset_out), 64'(0));
    check("wrap_hex", 64'(bus.hex_out), 64'({S_H, S_E, S_L, S_L, S_O}));

    // Step right from 0 wraps to MSG_LEN-1.
    drive(1'b0, hello, 1'b0, 1'b1, 1'b1, cur_p);
    idle(2);
    check("right_off", 64'(bus.offset_out), 64'(7));
    check("right_hex", 64'(bus.hex_out), 64'({S_B, S_H, S_E, S_L, S_L}));
    drive(1'b0, hello, 1'b0, 1'b0, 1'b1, cur_p);
    idle(1);

    // Auto-scroll with period 3: eight advances in 32 clocks.
    cur_p = DW'(3);
    for (int i = 0; i < 32; i++) drive(1'b0, hello, 1'b1, 1'b0, 1'b0, cur_p);
    idle(1);
    check("auto_off", 64'(bus.offset_out), 64'(0));

    // Period 0 advances every cycle, right-going this time.
    cur_p = '0;
    for (int i = 0; i < 10; i++) drive(1'b0, hello, 1'b1, 1'b1, 1'b0, cur_p);
    idle(1);

    // Load coincident with an auto advance; step ignored while running.
    cur_p = DW'(3);
    for (int i = 0; i < 8 && m_cnt != 3; i++) drive(1'b0, hello, 1'b1, 1'b0, 1'b0, cur_p);
    check("pre_load_cnt", 64'(m_cnt), 64'(3));
    drive(1'b1, hello, 1'b1, 1'b0, 1'b0, cur_p);
    for (int i = 0; i < 3; i++) drive(1'b0, hello, 1'b1, 1'b0, 1'b1, cur_p);
    drive(1'b0, hello, 1'b1, 1'b0, 1'b0, cur_p);
    check("coinc_off", 64'(bus.offset_out), 64'(0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic ld, r, d, s;
      logic [3*ML-1:0] mi;
      ld = ($urandom_range(0, 24) == 0);
      r  = ($urandom_range(0, 2) != 0);
      d  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      mi = 24'($urandom);
      if ($urandom_range(0, 15) == 0) cur_p = DW'($urandom_range(0, 4));
      drive(ld, mi, r, d, s, cur_p);
    end

    // Asynchronous reset between edges.
    drive(1'b1, hello, 1'b0, 1'b0, 1'b0, cur_p);
    cur_p = DW'(1);
    for (int i = 0; i < 9; i++) drive(1'b0, hello, 1'b1, 1'b0, 1'b0, cur_p);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_hex", 64'(bus.hex_out), 64'({ND{S_B}}));
    check("async_off", 64'(bus.offset_out), 64'(0));
    check("async_adv", 64'(bus.adv_out), 64'(0));
    bus.run = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b0, hello, 1'b0, 1'b0, 1'($urandom_range(0, 1)), cur_p);
    idle(1);
    check("post_rst_hex", 64'(bus.hex_out), 64'({ND{S_B}}));
    drive(1'b1, hello, 1'b0, 1'b0, 1'b0, cur_p);
    idle(3);
    check("reload_hex", 64'(bus.hex_out), 64'({S_H, S_E, S_L, S_L, S_O}));

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
